// File: rtl/adpll_meas_pkg.sv
// Shared definitions for the ADPLL period-measurement sequencer.
//   meas_state_e    : FSM state encoding (IDLE, ARM, MEASURE, PRESENT = 0..3)
//   AVG_LOG2_MAX    : largest legal averaging exponent
//   avg_log2_legal  : parameter range check used at elaboration
//   sat_ones        : all-ones saturation value for a given counter width
package adpll_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_PRESENT = 2'd3
  } meas_state_e;

  localparam int AVG_LOG2_MAX = 4;

  function automatic bit avg_log2_legal(input int avg_log2);
    return (avg_log2 >= 0) && (avg_log2 <= AVG_LOG2_MAX);
  endfunction

  // All-ones value of a w-bit counter (w <= 63).
  function automatic logic [63:0] sat_ones(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// Synchronises an asynchronous trigger into the system clock and emits a
// registered one-cycle pulse on each synchronised rising edge.
//   clk        : system clock
//   reset      : asynchronous, active-high
//   trigger    : asynchronous trigger input
//   edge_pulse : one-cycle pulse per rising edge of trigger
module trigger_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      sync_prev  <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], trigger};
      sync_prev  <= sync[SYNC_STAGES-1];
      edge_pulse <= sync[SYNC_STAGES-1] & ~sync_prev;
    end
  end

endmodule

// File: rtl/period_meas_ctrl.sv
// Period-measurement sequencer: counts fpga_clk_i cycles between accepted
// trigger edges, averages 2^AVG_LOG2 samples and offers the result over a
// valid/ready handshake.
//   fpga_clk_i    : system clock
//   reset_i       : asynchronous, active-high
//   enable_i      : measurement enable, low returns to IDLE and drops results
//   trigger_i     : asynchronous trigger, rising edges delimit periods
//   ready_i       : downstream ready
//   period_o      : averaged period (all-ones on overflow)
//   valid_o       : period_o / overflow_o valid
//   overflow_o    : window aborted on counter saturation
//   count_clear_o : one-cycle pulse per accepted edge
//   busy_o        : state is ARM or MEASURE
module period_meas_ctrl
  import adpll_meas_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int AVG_LOG2    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             trigger_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] period_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             count_clear_o,
  output logic             busy_o
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  // nsamp needs at least one bit even when no averaging is done.
  localparam int NS_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NS_W-1:0]  NS_LAST = NS_W'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] CNT_SAT = WIDTH'(sat_ones(WIDTH));

  if (!avg_log2_legal(AVG_LOG2) || SYNC_STAGES < 2) begin : g_bad_param
    $error("period_meas_ctrl: illegal AVG_LOG2 or SYNC_STAGES");
  end

  meas_state_e      state;
  logic [WIDTH-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [NS_W-1:0]  nsamp;
  logic             edge_pulse;
  logic [WIDTH-1:0] sample;
  logic [ACC_W-1:0] acc_sum;

  trigger_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (fpga_clk_i),
    .reset      (reset_i),
    .trigger    (trigger_i),
    .edge_pulse (edge_pulse)
  );

  // cnt never exceeds 2^WIDTH-2, so the sample always fits in WIDTH bits.
  assign sample  = cnt + WIDTH'(1);
  assign acc_sum = acc + ACC_W'(sample);
  assign busy_o  = (state == ST_ARM) || (state == ST_MEASURE);

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      acc           <= '0;
      nsamp         <= '0;
      period_o      <= '0;
      valid_o       <= 1'b0;
      overflow_o    <= 1'b0;
      count_clear_o <= 1'b0;
    end else if (!enable_i) begin
      // Disable wins over everything, including a pending handshake.
      state         <= ST_IDLE;
      cnt           <= '0;
      acc           <= '0;
      nsamp         <= '0;
      period_o      <= '0;
      valid_o       <= 1'b0;
      overflow_o    <= 1'b0;
      count_clear_o <= 1'b0;
    end else begin
      count_clear_o <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          if (edge_pulse) begin
            state         <= ST_MEASURE;
            cnt           <= '0;
            acc           <= '0;
            nsamp         <= '0;
            count_clear_o <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (edge_pulse) begin
            // An edge in the saturation cycle still yields a valid sample.
            cnt           <= '0;
            count_clear_o <= 1'b1;
            if (nsamp == NS_LAST) begin
              state      <= ST_PRESENT;
              period_o   <= acc_sum[ACC_W-1:AVG_LOG2];
              overflow_o <= 1'b0;
              valid_o    <= 1'b1;
            end else begin
              acc   <= acc_sum;
              nsamp <= nsamp + NS_W'(1);
            end
          end else if (sample == CNT_SAT) begin
            state      <= ST_PRESENT;
            period_o   <= CNT_SAT;
            overflow_o <= 1'b1;
            valid_o    <= 1'b1;
          end else begin
            cnt <= sample;
          end
        end
        ST_PRESENT: begin
          // The edge that would start the next window is lost while waiting.
          if (ready_i) begin
            state   <= ST_ARM;
            valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meas_ctrl.sv
module tb_period_meas_ctrl;

  localparam int WIDTH    = 10;
  localparam int AVG_LOG2 = 2;
  localparam int SYNC     = 2;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             trigger;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] period_o;
  logic             valid_o;
  logic             overflow_o;
  logic             count_clear_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;
  int clear_cnt = 0;
  logic [WIDTH:0] exp_q[$];
  int pq[$];
  bit hold_rdy  = 1'b0;
  bit force_rdy = 1'b0;

  always #5 clk = ~clk;

  period_meas_ctrl #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .SYNC_STAGES(SYNC)) dut (
    .fpga_clk_i    (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .trigger_i     (trigger),
    .ready_i       (ready),
    .period_o      (period_o),
    .valid_o       (valid_o),
    .overflow_o    (overflow_o),
    .count_clear_o (count_clear_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready is updated 2 time units after the edge so stimulus flags written at +1 apply in the same cycle.
  always @(posedge clk) begin
    #2;
    ready = hold_rdy ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
  end

  // Monitor: pops on every completed transfer and checks output stability under back-pressure.
  logic [WIDTH-1:0] held_p;
  logic             held_o;
  bit               held_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (count_clear_o) clear_cnt++;
      if (valid_o && held_v) check("hold_stable", {overflow_o, period_o}, {held_o, held_p});
      if (valid_o && ready && enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got period 0x%0h ovf %0b with nothing expected", period_o, overflow_o);
        end else begin
          check("result", {overflow_o, period_o}, exp_q.pop_front());
        end
        held_v = 1'b0;
      end else begin
        held_v = valid_o;
        held_p = period_o;
        held_o = overflow_o;
      end
    end
  end

  // Rising edges of trigger_i spaced by the entries of pq, then a short tail.
  task automatic drive_edges();
    trigger = 1'b1;
    foreach (pq[i]) begin
      repeat (pq[i] / 2) tick();
      trigger = 1'b0;
      repeat (pq[i] - pq[i] / 2) tick();
      trigger = 1'b1;
    end
    repeat (4) tick();
    trigger = 1'b0;
    repeat (4) tick();
  endtask

  // One measurement window. ovf_tail: trigger stays quiet after the last edge
  // so the counter saturates. extra: trigger keeps toggling at 100 cycles
  // while ready is held low.
  task automatic run_window(input bit push, input bit ovf_tail, input int extra);
    int base;
    int sum;
    bit timed_out;
    logic [WIDTH:0] e;
    base = clear_cnt;
    sum = 0;
    foreach (pq[i]) sum += pq[i];
    if (ovf_tail) e = {1'b1, {WIDTH{1'b1}}};
    else          e = {1'b0, WIDTH'(sum / NAVG)};
    if (push) exp_q.push_back(e);
    drive_edges();
    for (int k = 0; k < extra; k++) begin
      trigger = 1'b1;
      repeat (50) tick();
      trigger = 1'b0;
      repeat (50) tick();
    end
    if (!push) return;
    hold_rdy = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    check("handshake_timeout", {31'd0, timed_out}, 32'd0);
    check("clear_count", clear_cnt - base, pq.size() + 1);
    repeat (2) tick();
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    trigger = 1'b0;
    repeat (3) tick();
    check("rst_period", period_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_clear", count_clear_o, 0);
    check("rst_busy", busy_o, 0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle_busy", busy_o, 0);
    enable = 1'b1;
    repeat (2) tick();
    check("arm_busy", busy_o, 1);

    // Directed windows: plain, averaged, truncating, max sample, near max.
    pq = '{100, 100, 100, 100};     run_window(1, 0, 0);
    pq = '{100, 102, 98, 104};      run_window(1, 0, 0);
    pq = '{100, 101, 101, 101};     run_window(1, 0, 0);
    pq = '{1023, 1023, 1023, 1023}; run_window(1, 0, 0);
    pq = '{1022, 1023, 1021, 1020}; run_window(1, 0, 0);

    // Saturation: after a single edge, and after two partial samples.
    pq = {};                        run_window(1, 1, 0);
    pq = '{50, 60};                 run_window(1, 1, 0);

    // Back-pressure: result held while the trigger keeps running.
    hold_rdy = 1'b1;
    pq = '{100, 100, 100, 100};     run_window(1, 0, 5);
    pq = '{100, 100, 100, 100};     run_window(1, 0, 0);

    // Randomised windows.
    for (int w = 0; w < 10; w++) begin
      pq = {};
      for (int i = 0; i < NAVG; i++) pq.push_back($urandom_range(8, 300));
      run_window(1, 0, 0);
    end

    // Asynchronous reset in the middle of MEASURE.
    pq = '{100, 100};
    drive_edges();
    repeat (30) tick();
    check("busy_before_reset", busy_o, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_clear", count_clear_o, 0);
    check("async_rst_period", period_o, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    pq = '{100, 100, 100, 100};     run_window(1, 0, 0);

    // Enable dropped while a result waits with ready low.
    hold_rdy = 1'b1;
    pq = '{100, 100, 100, 100};     run_window(0, 0, 0);
    wait_valid();
    enable = 1'b0;
    tick();
    check("dis_valid", valid_o, 0);
    check("dis_period", period_o, 0);
    check("dis_busy", busy_o, 0);
    enable = 1'b1;
    repeat (2) tick();

    // Enable dropped in the same cycle as a would-be handshake.
    pq = '{100, 100, 100, 100};     run_window(0, 0, 0);
    wait_valid();
    hold_rdy = 1'b0;
    force_rdy = 1'b1;
    enable = 1'b0;
    tick();
    check("dis_hs_valid", valid_o, 0);
    check("dis_hs_ovf", overflow_o, 0);
    force_rdy = 1'b0;
    enable = 1'b1;
    repeat (2) tick();

    pq = '{100, 100, 100, 100};     run_window(1, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meas_ctrl.md
# period_meas_ctrl

Sequencer for the ADPLL period-measurement datapath. It synchronises an asynchronous trigger (reference or DCO-derived edge) into `fpga_clk_i` and runs the cycle counter, clearing it on each accepted edge. It captures and optionally averages the count over 2^AVG_LOG2 periods and presents the result to the loop filter over a valid/ready handshake. It replaces free-running trigger-clocked capture with a fully synchronous, back-pressured measurement.

## Interface
- `WIDTH`, 20: width of the period counter and of `period_o`.
- `AVG_LOG2`, 0: log2 of the number of periods averaged per result (0 to 4).
- `SYNC_STAGES`, 2: synchroniser depth for `trigger_i` (2 or more).

- `fpga_clk_i`  in  1  system clock; all state on its rising edge.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `enable_i`  in  1  measurement enable; low forces IDLE.
- `trigger_i`  in  1  asynchronous trigger; rising edges delimit periods.
- `ready_i`  in  1  downstream ready.
- `period_o`  out  WIDTH  averaged period in `fpga_clk_i` cycles.
- `valid_o`  out  1  `period_o`/`overflow_o` valid.
- `overflow_o`  out  1  window aborted on counter saturation.
- `count_clear_o`  out  1  one-cycle pulse on every accepted edge (counter cleared).
- `busy_o`  out  1  state is ARM or MEASURE.

## Operation
- Edge pulse: `trigger_i` passes through SYNC_STAGES flops, then a rising-edge detect gives a 1-cycle `edge` pulse.
- States: IDLE, ARM, MEASURE, PRESENT. Encoding 2 bits, values 0 to 3 in that order.
- IDLE goes to ARM when `enable_i`=1.
- ARM goes to MEASURE on `edge`. That cycle: `cnt` <= 0, `acc` <= 0, `nsamp` <= 0, `count_clear_o`=1.
- In MEASURE, each cycle without `edge`: `cnt` <= `cnt`+1.
- In MEASURE, on `edge`:
  - sample = `cnt`+1; `acc` += sample; `cnt` <= 0; `count_clear_o`=1; `nsamp`++.
  - When `nsamp` reaches 2^AVG_LOG2−1 (the last sample): go to PRESENT, `period_o` <= (`acc`+sample)[WIDTH+AVG_LOG2−1:AVG_LOG2] (truncating), `overflow_o` <= 0.
- Overflow: in MEASURE, when `cnt`+1 = 2^WIDTH−1 and there is no `edge`, go to PRESENT with `period_o` <= all-ones and `overflow_o` <= 1. The partial accumulation is discarded.
- PRESENT:
  - `valid_o`=1, `period_o`/`overflow_o` stable.
  - `edge` ignored, `count_clear_o`=0.
  - When `valid_o`&&`ready_i`, go to ARM (one period is lost by design).
- `enable_i`=0 in any state: IDLE next cycle, `valid_o` drops without handshake, result discarded.
- Accumulator width: WIDTH+AVG_LOG2, never wraps (every sample is ≤ 2^WIDTH−1).

## Timing
- Reset values:
  - `period_o`=0, `valid_o`=0, `overflow_o`=0, `count_clear_o`=0, `busy_o`=0.
  - State IDLE; `cnt`, `acc`, `nsamp` = 0; synchroniser flops 0.
- Trigger-to-`edge` latency: SYNC_STAGES+1 cycles from the first `fpga_clk_i` edge that samples `trigger_i` high.
- `trigger_i` high time and low time must each be ≥ SYNC_STAGES+1 cycles. Shorter pulses may be missed (not flagged).
- IDLE to ARM takes 1 cycle after `enable_i` rises. An `edge` arriving in the IDLE cycle is dropped.
- `valid_o` and `count_clear_o` are registered. `valid_o` rises the cycle after the final `edge` or the saturation cycle.
- `count_clear_o` is coincident with the state/`cnt` update of the edge cycle, as seen at the output one cycle later.
- Result: edges P cycles apart give sample P exactly.
- `ready_i` may be high before `valid_o`. The transfer completes in the first cycle where both are high.
- Simultaneous events:
  - `enable_i`=0 and handshake in the same cycle: IDLE wins, no transfer counted.
  - `edge` and saturation in the same cycle: `edge` wins, sample = 2^WIDTH−1, no overflow.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. Restart from IDLE on the first clock after release.

## Structure
- Shared package/header `adpll_meas_pkg`: state encodings (ST_IDLE..ST_PRESENT), AVG_LOG2 legal-range check constant, all-ones saturation macro.
- One sub-module, `trigger_sync_edge`, parameterised SYNC_STAGES: synchroniser chain plus rising-edge detect, output `edge`. This block holds the FSM, counter, accumulator and output registers.

## Test plan
- WIDTH=20, AVG_LOG2=0, trigger period 100 cycles, `ready_i`=1 -> `period_o`=100, `valid_o` pulses once per result, `count_clear_o` pulses 100 cycles apart.
- AVG_LOG2=2, periods 100,102,98,104 -> single result `period_o`=101, `overflow_o`=0.
- AVG_LOG2=2, periods 100,101,101,101 (sum 403) -> `period_o`=100 (truncation).
- WIDTH=8, one edge then none -> after 255 cycles in MEASURE, `period_o`=0xFF, `overflow_o`=1, `valid_o`=1.
- `ready_i` low for 500 cycles with a 100-cycle trigger -> `valid_o` held, `period_o` stable, no `count_clear_o`. After `ready_i` rises: ARM, next result still 100.
- `reset_i` pulsed mid-MEASURE, then `enable_i` dropped during PRESENT -> all outputs 0 immediately/next cycle. First result after recovery is correct (100).
